mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory responder: loads a program image, serves CPU accesses while the
// CPU runs, then streams the whole array out and parks in DONE.
module mem_responder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [15:0]           mem_value_i,
  input  logic                  mem_enable_i,
  input  logic                  mem_wr_en_i,
  input  logic                  mem_rd_en_i,
  output logic [15:0]           mem_value_o,
  input  logic                  end_program_i,
  input  logic                  load_valid_i,
  input  logic                  load_last_i,
  input  logic [15:0]           load_data_i,
  output logic                  load_ready_o,
  output logic                  dump_valid_o,
  output logic [ADDR_WIDTH-1:0] dump_addr_o,
  output logic [15:0]           dump_data_o,
  input  logic                  dump_ready_i,
  output logic                  cpu_rst_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DUMP,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [15:0]           mem [DEPTH];

  logic                  load_fire;
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [15:0]           wd;

  always_comb begin
    load_fire = (state == LOAD) && load_valid_i && load_ready_o;
    cpu_wr    = (state == RUN) && mem_enable_i && mem_wr_en_i;
    cpu_rd    = (state == RUN) && mem_enable_i && mem_rd_en_i;
    we        = 1'b0;
    wa        = ptr;
    wd        = load_data_i;
    if (load_fire) begin
      we = 1'b1;
    end else if (cpu_wr) begin
      we = 1'b1;
      wa = mem_addr_i;
      wd = mem_value_i;
    end
  end

  // Array is deliberately not reset so a reload keeps untouched words.
  always_ff @(posedge clk_i) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= LOAD;
      ptr          <= '0;
      cpu_rst_o    <= 1'b1;
      load_ready_o <= 1'b1;
      mem_value_o  <= '0;
      dump_valid_o <= 1'b0;
      dump_addr_o  <= '0;
      dump_data_o  <= '0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      cpu_rst_o <= (state != RUN);
      unique case (state)
        LOAD: begin
          if (load_fire) begin
            if (load_last_i || ptr == LAST) begin
              state        <= RUN;
              ptr          <= '0;
              load_ready_o <= 1'b0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        RUN: begin
          if (cpu_rd) mem_value_o <= mem[mem_addr_i];
          if (cpu_rd && cpu_wr) error_o <= 1'b1;
          if (end_program_i) begin
            state <= DUMP;
            ptr   <= '0;
          end
        end
        DUMP: begin
          // Fetch the next word whenever the output slot is free or leaving.
          if (dump_valid_o && dump_ready_i && dump_addr_o == LAST) begin
            state        <= DONE;
            dump_valid_o <= 1'b0;
            done_o       <= 1'b1;
          end else if (!dump_valid_o || dump_ready_i) begin
            dump_valid_o <= 1'b1;
            dump_addr_o  <= ptr;
            dump_data_o  <= mem[ptr];
            ptr          <= ptr + 1'b1;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a plain array model.
module tb_mem_responder;

  localparam int AW = 8;
  localparam int N  = 256;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [AW-1:0] mem_addr_i;
  logic [15:0]   mem_value_i;
  logic          mem_enable_i;
  logic          mem_wr_en_i;
  logic          mem_rd_en_i;
  logic [15:0]   mem_value_o;
  logic          end_program_i;
  logic          load_valid_i;
  logic          load_last_i;
  logic [15:0]   load_data_i;
  logic          load_ready_o;
  logic          dump_valid_o;
  logic [AW-1:0] dump_addr_o;
  logic [15:0]   dump_data_o;
  logic          dump_ready_i;
  logic          cpu_rst_o;
  logic          done_o;
  logic          error_o;

  logic [15:0] model [N];
  logic [15:0] exp_val;
  int checks = 0;
  int failures = 0;

  mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_addr_i(mem_addr_i), .mem_value_i(mem_value_i),
    .mem_enable_i(mem_enable_i), .mem_wr_en_i(mem_wr_en_i),
    .mem_rd_en_i(mem_rd_en_i), .mem_value_o(mem_value_o),
    .end_program_i(end_program_i),
    .load_valid_i(load_valid_i), .load_last_i(load_last_i),
    .load_data_i(load_data_i), .load_ready_o(load_ready_o),
    .dump_valid_o(dump_valid_o), .dump_addr_o(dump_addr_o),
    .dump_data_o(dump_data_o), .dump_ready_i(dump_ready_i),
    .cpu_rst_o(cpu_rst_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_addr_i = '0; mem_value_i = '0;
    mem_enable_i = 0; mem_wr_en_i = 0; mem_rd_en_i = 0;
    end_program_i = 0; load_valid_i = 0; load_last_i = 0;
    load_data_i = '0; dump_ready_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
  endtask

  task automatic cpu_op(input logic [AW-1:0] a, input logic [15:0] v,
                        input logic en, input logic wr, input logic rd);
    mem_addr_i = a; mem_value_i = v;
    mem_enable_i = en; mem_wr_en_i = wr; mem_rd_en_i = rd;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cpu_rst_o, load_ready_o, dump_valid_o, done_o, error_o} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=11000",
               {cpu_rst_o, load_ready_o, dump_valid_o, done_o, error_o});
    end
    checks++;
    if (mem_value_o !== 16'h0 || dump_addr_o !== '0 || dump_data_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0/0/0",
               mem_value_o, dump_addr_o, dump_data_o);
    end
  endtask

  task automatic test_full_load();
    for (int i = 0; i < N; i++) begin
      load_valid_i = 1; load_last_i = 0;
      load_data_i = 16'($urandom);
      model[i] = load_data_i;
      if (i == N - 1) begin
        checks++;
        if (load_ready_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
          failures++;
          $display("FAIL full_load_pre ready=%b cpu_rst=%b exp=1/1",
                   load_ready_o, cpu_rst_o);
        end
      end
      tick();
    end
    idle();
    checks++;
    if (load_ready_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL auto_run ready=%b cpu_rst=%b exp=0/1", load_ready_o, cpu_rst_o);
    end
    tick();
    checks++;
    if (cpu_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL auto_run_cpu_rst got=%b exp=0", cpu_rst_o);
    end
    for (int k = 0; k < 8; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      cpu_op(a, 16'h0, 1, 0, 1);
      checks++;
      if (mem_value_o !== model[a]) begin
        failures++;
        $display("FAIL full_load_read addr=%0d got=%h exp=%h", a, mem_value_o, model[a]);
      end
    end
  endtask

  task automatic test_load3();
    logic [15:0] w [3];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_valid_i = 1; load_data_i = w[i]; load_last_i = (i == 2);
      mem_addr_i = 8'd100; mem_value_i = 16'hDEAD;
      mem_enable_i = 1; mem_wr_en_i = 1; mem_rd_en_i = 1;
      model[i] = w[i];
      tick();
    end
    idle();
    checks++;
    if (load_ready_o !== 1'b0 || cpu_rst_o !== 1'b1 || mem_value_o !== 16'h0
        || error_o !== 1'b0) begin
      failures++;
      $display("FAIL load3_enter_run ready=%b cpu_rst=%b val=%h err=%b exp=0/1/0000/0",
               load_ready_o, cpu_rst_o, mem_value_o, error_o);
    end
    tick();
    checks++;
    if (cpu_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL load3_cpu_rst got=%b exp=0", cpu_rst_o);
    end
    cpu_op(8'd2, 16'h0, 1, 0, 1);
    checks++;
    if (mem_value_o !== 16'h3333) begin
      failures++;
      $display("FAIL load3_read2 got=%h exp=3333", mem_value_o);
    end
    cpu_op(8'd100, 16'h0, 1, 0, 1);
    checks++;
    if (mem_value_o !== model[100]) begin
      failures++;
      $display("FAIL load_ignores_cpu got=%h exp=%h", mem_value_o, model[100]);
    end
  endtask

  task automatic test_run_ops();
    cpu_op(8'd5, 16'hBEEF, 1, 1, 0);
    model[5] = 16'hBEEF;
    cpu_op(8'd5, 16'h0, 1, 0, 1);
    checks++;
    if (mem_value_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_then_read got=%h exp=beef", mem_value_o);
    end
    cpu_op(8'd5, 16'h1234, 0, 1, 0);
    cpu_op(8'd0, 16'h0, 0, 0, 1);
    checks++;
    if (mem_value_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL rd_no_enable got=%h exp=beef", mem_value_o);
    end
    cpu_op(8'd5, 16'h0, 1, 0, 1);
    checks++;
    if (mem_value_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_no_enable got=%h exp=beef", mem_value_o);
    end
    exp_val = 16'hBEEF;
    for (int k = 0; k < 80; k++) begin
      int unsigned kind;
      logic [AW-1:0] a;
      logic [15:0] v;
      kind = $urandom_range(0, 3);
      a = AW'($urandom_range(0, 15));
      v = 16'($urandom);
      unique case (kind)
        0: begin cpu_op(a, v, 1, 1, 0); model[a] = v; end
        1: begin cpu_op(a, v, 1, 0, 1); exp_val = model[a]; end
        2: cpu_op(a, v, 0, 1, 0);
        default: cpu_op(a, v, 0, 0, 1);
      endcase
      checks++;
      if (mem_value_o !== exp_val) begin
        failures++;
        $display("FAIL rand_run k=%0d addr=%0d got=%h exp=%h", k, a, mem_value_o, exp_val);
      end
    end
    checks++;
    if (error_o !== 1'b0) begin
      failures++;
      $display("FAIL no_spurious_error got=%b exp=0", error_o);
    end
  endtask

  task automatic test_rdwr();
    cpu_op(8'd7, 16'h0007, 1, 1, 0);
    model[7] = 16'h0007;
    cpu_op(8'd7, 16'hAAAA, 1, 1, 1);
    model[7] = 16'hAAAA;
    checks++;
    if (mem_value_o !== 16'h0007 || error_o !== 1'b1) begin
      failures++;
      $display("FAIL rdwr_same got=%h err=%b exp=0007/1", mem_value_o, error_o);
    end
    tick();
    tick();
    cpu_op(8'd7, 16'h0, 1, 0, 1);
    exp_val = 16'hAAAA;
    checks++;
    if (mem_value_o !== 16'hAAAA || error_o !== 1'b1) begin
      failures++;
      $display("FAIL rdwr_after got=%h err=%b exp=aaaa/1", mem_value_o, error_o);
    end
  endtask

  task automatic test_dump(input bit rand_ready);
    logic [15:0] v;
    int idx;
    int cyc;
    bit acc;
    v = 16'($urandom);
    mem_addr_i = 8'd9; mem_value_i = v;
    mem_enable_i = 1; mem_wr_en_i = 1; end_program_i = 1;
    tick();
    idle();
    model[9] = v;
    checks++;
    if (dump_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL dump_first_cycle valid=%b exp=0", dump_valid_o);
    end
    tick();
    checks++;
    if (dump_valid_o !== 1'b1 || dump_addr_o !== '0) begin
      failures++;
      $display("FAIL dump_second_cycle valid=%b addr=%0d exp=1/0", dump_valid_o, dump_addr_o);
    end
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 3000) begin
      dump_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dump_valid_o) begin
        checks++;
        if (dump_addr_o !== 8'(idx) || dump_data_o !== model[idx]) begin
          failures++;
          $display("FAIL dump_word got=%0d:%h exp=%0d:%h",
                   dump_addr_o, dump_data_o, idx, model[idx]);
        end
      end
      acc = dump_valid_o && dump_ready_i;
      tick();
      cyc++;
      if (acc) idx++;
    end
    idle();
    checks++;
    if (idx != N) begin
      failures++;
      $display("FAIL dump_timeout got=%0d words exp=%0d", idx, N);
    end
    checks++;
    if (done_o !== 1'b1 || dump_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL dump_done done=%b valid=%b exp=1/0", done_o, dump_valid_o);
    end
  endtask

  task automatic test_done_terminal();
    for (int k = 0; k < 10; k++) begin
      load_valid_i = 1'($urandom); load_last_i = 1'($urandom);
      end_program_i = 1'($urandom); dump_ready_i = 1'($urandom);
      mem_enable_i = 1; mem_rd_en_i = 1'($urandom);
      mem_wr_en_i = 1'($urandom); mem_addr_i = AW'($urandom);
      tick();
      checks++;
      if ({done_o, dump_valid_o, load_ready_o, cpu_rst_o} !== 4'b1001
          || mem_value_o !== exp_val) begin
        failures++;
        $display("FAIL done_terminal flags=%b val=%h exp=1001/%h",
                 {done_o, dump_valid_o, load_ready_o, cpu_rst_o}, mem_value_o, exp_val);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_dump();
    int n;
    do_reset();
    load_valid_i = 1; load_last_i = 1; load_data_i = 16'($urandom);
    model[0] = load_data_i;
    tick();
    idle();
    tick();
    end_program_i = 1;
    tick();
    end_program_i = 0;
    dump_ready_i = 1;
    n = 0;
    while (!(dump_valid_o && dump_addr_o == 8'd40) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL reach_addr40 got=%0d exp=40", dump_addr_o);
    end
    #1;
    rst_i = 1;
    #1;
    checks++;
    if ({cpu_rst_o, load_ready_o, dump_valid_o, done_o, error_o} !== 5'b11000
        || mem_value_o !== 16'h0 || dump_addr_o !== '0 || dump_data_o !== 16'h0) begin
      failures++;
      $display("FAIL async_reset flags=%b val=%h addr=%0d data=%h exp=11000/0/0/0",
               {cpu_rst_o, load_ready_o, dump_valid_o, done_o, error_o},
               mem_value_o, dump_addr_o, dump_data_o);
    end
    idle();
    tick();
    rst_i = 0;
    load_valid_i = 1; load_last_i = 1; load_data_i = 16'($urandom);
    model[0] = load_data_i;
    tick();
    idle();
    tick();
    test_dump(1'b0);
  endtask

  initial begin
    rst_i = 1;
    idle();
    test_reset();
    test_full_load();
    test_load3();
    test_run_ops();
    test_rdwr();
    test_dump(1'b1);
    test_done_terminal();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
